// File: rtl/evt_rr_scheduler.sv
// Edge-triggered event collector with round-robin, gated, timestamped dispatch.
// Per-requester edge/pending/overflow state lives in evt_rr_lane; the top holds the arbiter FSM.

module evt_rr_lane (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic grant,
  input  logic clr_ovf,
  output logic pending,
  output logic ovf
);
  logic req_prev_q, req_prev_d;
  logic pending_q, pending_d;
  logic ovf_q, ovf_d;
  logic rise;

  // A rise coinciding with the grant of this lane is a fresh event, not an overflow.
  always_comb begin
    rise       = req & ~req_prev_q;
    req_prev_d = req;
    pending_d  = rise | (pending_q & ~grant);
    ovf_d      = (ovf_q & ~clr_ovf) | (rise & pending_q & ~grant);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_prev_q <= 1'b0;
      pending_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      req_prev_q <= req_prev_d;
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
    end
  end

  assign pending = pending_q;
  assign ovf     = ovf_q;
endmodule

module evt_rr_scheduler #(
  parameter int N   = 4,
  parameter int TW  = 16,
  parameter int GAP = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 gate,
  input  logic                 clr_ovf,
  output logic                 fire_valid,
  output logic [$clog2(N)-1:0] fire_id,
  output logic [TW-1:0]        fire_time,
  output logic [N-1:0]         pending,
  output logic [N-1:0]         ovf,
  output logic                 busy
);
  localparam int IW = $clog2(N);
  localparam int CW = (GAP < 2) ? 1 : $clog2(GAP + 1);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [TW-1:0]   ts_q, ts_d;
  logic            fire_valid_q, fire_valid_d;
  logic [IW-1:0]   fire_id_q, fire_id_d;
  logic [TW-1:0]   fire_time_q, fire_time_d;

  logic            gnt_any, grant_en;
  logic [IW-1:0]   gnt_idx, cand;
  logic [N-1:0]    grant;

  for (genvar i = 0; i < N; i++) begin : g_lane
    evt_rr_lane u_lane (
      .clk     (clk),
      .reset   (reset),
      .req     (req[i]),
      .grant   (grant[i]),
      .clr_ovf (clr_ovf),
      .pending (pending[i]),
      .ovf     (ovf[i])
    );
  end

  // First pending lane scanning upward from ptr, wrapping at N.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (!gnt_any && pending[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign grant_en = (state_q == IDLE) && !gate && gnt_any;
  assign grant    = grant_en ? (N'(1) << gnt_idx) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ptr_q        <= '0;
      ts_q         <= '0;
      fire_valid_q <= 1'b0;
      fire_id_q    <= '0;
      fire_time_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      ts_q         <= ts_d;
      fire_valid_q <= fire_valid_d;
      fire_id_q    <= fire_id_d;
      fire_time_q  <= fire_time_d;
    end
  end

  // HOLD loaded with GAP leaves exactly GAP grant-free edges before IDLE again.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_en && (GAP > 0)) begin
          state_d = HOLD;
          cnt_d   = CW'(GAP);
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ts_d         = ts_q + 1'b1;
    fire_valid_d = grant_en;
    fire_id_d    = fire_id_q;
    fire_time_d  = fire_time_q;
    ptr_d        = ptr_q;
    if (grant_en) begin
      fire_id_d   = gnt_idx;
      fire_time_d = ts_q;
      ptr_d       = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign fire_valid = fire_valid_q;
  assign fire_id    = fire_id_q;
  assign fire_time  = fire_time_q;
  assign busy       = (state_q == HOLD) | (|pending);
endmodule

// File: doc/evt_rr_scheduler.md
Name: evt_rr_scheduler

Overview:
- Collects edge-triggered events from N requesters and dispatches them one at a time, in round-robin order.
- Each dispatch is a timestamped one-cycle fire pulse.
- A level gate input suppresses dispatch while high, in the manner of an event qualifier.
- Sits between asynchronous-ish event sources (resets, status strobes) and a shared downstream consumer such as a logger or display monitor that accepts one event per dispatch.

Parameters:
- N, 4, number of requesters (2..16).
- TW, 16, timestamp counter width.
- GAP, 2, idle cycles enforced after each dispatch (0 = back-to-back allowed).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  per-requester event lines; a rising edge posts an event.
- gate  input  1  dispatch inhibit; no grant is issued while high.
- clr_ovf  input  1  one-cycle pulse that clears all overflow flags.
- fire_valid  output  1  one-cycle pulse marking a dispatched event.
- fire_id  output  $clog2(N)  index of the dispatched requester.
- fire_time  output  TW  timestamp of the dispatch decision.
- pending  output  N  per-requester pending flags.
- ovf  output  N  sticky flags; an event arrived while already pending.
- busy  output  1  high in the HOLD state or when any pending bit is set.

Behaviour:
- Clocking and reset:
  - Clock is clk; reset is asynchronous and active-high.
  - Reset clears everything to 0: fire_valid, fire_id, fire_time, pending, ovf, busy, the req_prev register, the timestamp, the round-robin pointer, the hold counter. FSM goes to IDLE.
- Timestamp:
  - ts increments every clk edge from 0 after reset.
  - It wraps from 2^TW-1 to 0 with no flag.
- Edge detection:
  - rise[i] = req[i] & ~req_prev[i]; req_prev is registered every cycle.
  - Because req_prev resets to 0, a req held high through reset release produces one event on the first edge after release.
- Pending and overflow update, per edge:
  - A rise on a bit with pending clear sets pending.
  - A rise on a bit with pending already set, and not granted this edge, sets ovf[i]; pending stays 1.
  - A rise on the bit being granted this edge sets pending (new event) with no ovf.
  - A grant with no rise clears pending.
  - clr_ovf clears all ovf bits. A simultaneous new overflow on the same edge wins (bit ends set).
- FSM states: IDLE, HOLD.
- IDLE:
  - If gate==0 and any pending bit is set, grant the first set bit, scanning upward from ptr with wrap.
  - Registered outputs on that edge: fire_valid=1, fire_id=index, fire_time=current ts (value before increment).
  - ptr becomes (index+1) mod N.
  - If GAP>0: go to HOLD and load the counter with GAP. Otherwise remain in IDLE, so a grant is possible every cycle.
  - If gate==1 or nothing is pending: fire_valid=0; fire_id and fire_time hold their last values.
- HOLD:
  - Counter decrements each edge; the FSM returns to IDLE when it reaches 1.
  - This gives exactly GAP cycles with no grant.
  - Gate changes do not affect the countdown.
- Latency: a rise sampled at edge k sets pending at k. The earliest fire_valid is at edge k+1, if IDLE and gate==0 before that edge.
- Gate: it only blocks new grants. Events still accumulate while gate is high. An in-flight fire_valid pulse is not cancelled.
- Mid-operation reset: in-flight pending events and ovf are discarded. No fire_valid is issued after reset without a new rising edge.

Test Plan:
- Single event: reset, then req[2] rises before edge 5 → pending[2]=1 at edge 5; fire_valid=1, fire_id=2 at edge 6; pending[2]=0.
- Round-robin: N=4, GAP=0, req=4'b1111 rising together → fire_id sequence 0,1,2,3 on four consecutive cycles. Then req[0] and req[3] re-pulse with ptr=0 → 0 then 3.
- Gate and HOLD: gate=1 while req[1] and req[3] rise, held 10 cycles → no fire, pending=4'b1010. Gate drops → fire_id 1, then 3 exactly GAP+1=3 cycles later.
- Overflow: req[0] pulses twice while gate=1 → ovf[0]=1 and one dispatch after gate drops. clr_ovf pulse → ovf=0.
- Timestamp wrap: TW=4, dispatch at ts=15 and again 2 cycles later → fire_time 15 then 1.
- Async reset mid-HOLD with pending=4'b0110 → all outputs 0 immediately. req[1] held high through release → one fire_id=1 at the second edge after release.
